// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled/clearable register among N_REQ requesters.
// Async requests are synchronised, edge-detected, queued, then written one at a time with a hold-off.
module reg_write_arbiter #(
    parameter int WIDTH       = 5,
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic                   clr_req,
    output logic                   reg_en,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   reg_clr,
    output logic [N_REQ-1:0]       grant,
    output logic [ID_W-1:0]        last_id,
    output logic                   busy,
    output logic [N_REQ-1:0]       pending
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, HOLD} state_t;

    state_t             state, state_n;
    logic [N_REQ-1:0]   req_s1, req_s2, req_s3, req_rise;
    logic               clr_s1, clr_s2, clr_s3, clr_rise;
    logic [N_REQ-1:0]   pend_q, pend_n, pend_clr;
    logic               clr_pend, cpend_n, cpend_clr;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ID_W-1:0]    ptr, ptr_n, win, id_n;
    logic               any;
    logic               en_n, clr_n, busy_n;
    logic [N_REQ-1:0]   grant_n;
    logic [WIDTH-1:0]   d_n;

    assign req_rise = req_s2 & ~req_s3;
    assign clr_rise = clr_s2 & ~clr_s3;
    assign pending  = pend_q;

    // Search ascends from the RR pointer, wrapping modulo N_REQ; first set bit wins.
    always_comb begin
        logic [ID_W:0] idx;
        any = 1'b0;
        win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!any && pend_q[idx[ID_W-1:0]]) begin
                any = 1'b1;
                win = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        en_n      = 1'b0;
        clr_n     = 1'b0;
        grant_n   = '0;
        d_n       = reg_d;
        id_n      = last_id;
        pend_clr  = '0;
        cpend_clr = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    state_n   = CLEAR;
                    clr_n     = 1'b1;
                    d_n       = '0;
                    id_n      = '0;
                    cpend_clr = 1'b1;
                end else if (any) begin
                    state_n       = WRITE;
                    en_n          = 1'b1;
                    grant_n[win]  = 1'b1;
                    d_n           = req_data[win*WIDTH +: WIDTH];
                    id_n          = win;
                    pend_clr[win] = 1'b1;
                    ptr_n         = (win == LAST) ? '0 : win + 1'b1;
                end
            end
            WRITE, CLEAR: begin
                state_n = HOLD;
                cnt_n   = CNT_W'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // A fresh edge on the grant edge re-queues the requester (set wins).
        pend_n  = (pend_q & ~pend_clr) | req_rise;
        cpend_n = (clr_pend & ~cpend_clr) | clr_rise;
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_s1   <= '0;
            req_s2   <= '0;
            req_s3   <= '0;
            clr_s1   <= 1'b0;
            clr_s2   <= 1'b0;
            clr_s3   <= 1'b0;
            pend_q   <= '0;
            clr_pend <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
            reg_en   <= 1'b0;
            reg_clr  <= 1'b0;
            reg_d    <= '0;
            grant    <= '0;
            last_id  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            req_s1   <= req;
            req_s2   <= req_s1;
            req_s3   <= req_s2;
            clr_s1   <= clr_req;
            clr_s2   <= clr_s1;
            clr_s3   <= clr_s2;
            pend_q   <= pend_n;
            clr_pend <= cpend_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            reg_en   <= en_n;
            reg_clr  <= clr_n;
            reg_d    <= d_n;
            grant    <= grant_n;
            last_id  <= id_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: latency, round robin, clear priority,
// level/edge behaviour and async reset, with hand-computed expectations.
module tb_reg_write_arbiter;

    localparam int WIDTH = 5;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int HOLD  = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic                   clr_req;
    logic                   reg_en;
    logic [WIDTH-1:0]       reg_d;
    logic                   reg_clr;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        last_id;
    logic                   busy;
    logic [N_REQ-1:0]       pending;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int overlap  = 0;
    int base;

    reg_write_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .HOLD_CYCLES(HOLD)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .req_data(req_data), .clr_req(clr_req),
        .reg_en(reg_en), .reg_d(reg_d), .reg_clr(reg_clr), .grant(grant),
        .last_id(last_id), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_en) en_cnt++;
        if (reg_en && reg_clr) overlap++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        clr_req = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        clr_req  = 1'b0;
        req_data = {5'd0, 5'd0, 5'd0, 5'h15};
        step(2);
        chk("rst_en", reg_en, 0);
        chk("rst_d", reg_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_grant", grant, 0);
        reset = 1'b0;
        step(2);

        // single request latency
        req = 4'b0001;
        step(2);
        chk("t1_pend_e1", pending, 0);
        step(1);
        chk("t1_pend_e2", pending, 4'b0001);
        chk("t1_en_e2", reg_en, 0);
        step(1);
        chk("t1_en_e3", reg_en, 1);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_d", reg_d, 5'h15);
        chk("t1_id", last_id, 0);
        chk("t1_busy", busy, 1);
        chk("t1_pend_clr", pending, 0);
        step(1);
        chk("t1_en_pulse", reg_en, 0);
        chk("t1_grant_off", grant, 0);
        step(7);
        chk("t1_busy_e11", busy, 1);
        step(1);
        chk("t1_idle_e12", busy, 0);

        // all four at once, in order 0..3, 10 cycles apart
        req_data = {5'd4, 5'd3, 5'd2, 5'd1};
        do_reset();
        req = 4'b1111;
        step(3);
        chk("t2_pend", pending, 4'b1111);
        step(1);
        chk("t2_g0", grant, 4'b0001);
        chk("t2_d0", reg_d, 1);
        chk("t2_pend0", pending, 4'b1110);
        step(9);
        chk("t2_gap", reg_en, 0);
        step(1);
        chk("t2_en1", reg_en, 1);
        chk("t2_g1", grant, 4'b0010);
        chk("t2_d1", reg_d, 2);
        step(10);
        chk("t2_g2", grant, 4'b0100);
        chk("t2_d2", reg_d, 3);
        step(10);
        chk("t2_g3", grant, 4'b1000);
        chk("t2_d3", reg_d, 4);
        chk("t2_id3", last_id, 3);

        // pointer after granting 2 is 3, so 3 beats 0
        do_reset();
        req = 4'b0100;
        step(4);
        chk("t3_g2", grant, 4'b0100);
        chk("t3_id2", last_id, 2);
        step(1);
        req = 4'b1101;
        step(9);
        chk("t3_g3", grant, 4'b1000);
        chk("t3_d3", reg_d, 4);
        chk("t3_pend", pending, 4'b0001);
        step(10);
        chk("t3_g0", grant, 4'b0001);
        chk("t3_d0", reg_d, 1);
        req = '0;
        step(10);
        chk("t3_idle", busy, 0);

        // clear beats a simultaneous write
        clr_req = 1'b1;
        req     = 4'b0010;
        step(3);
        chk("t4_pend", pending, 4'b0010);
        step(1);
        chk("t4_clr", reg_clr, 1);
        chk("t4_en", reg_en, 0);
        chk("t4_d", reg_d, 0);
        chk("t4_id", last_id, 0);
        chk("t4_busy", busy, 1);
        step(1);
        chk("t4_clr_pulse", reg_clr, 0);
        step(9);
        chk("t4_en1", reg_en, 1);
        chk("t4_g1", grant, 4'b0010);
        chk("t4_d1", reg_d, 2);
        chk("t4_id1", last_id, 1);
        chk("t4_overlap", overlap, 0);

        // held level gives one grant
        do_reset();
        base = en_cnt;
        req  = 4'b0100;
        step(100);
        chk("t5_held", en_cnt - base, 1);

        // re-request during HOLD gives exactly one extra grant
        do_reset();
        base = en_cnt;
        req  = 4'b0100;
        step(6);
        chk("t5_in_hold", busy, 1);
        req = '0;
        step(3);
        req = 4'b0100;
        step(40);
        chk("t5_toggle", en_cnt - base, 2);

        // async reset mid-HOLD with three queued
        do_reset();
        req = 4'b1111;
        step(6);
        chk("t6_pend", pending, 4'b1110);
        chk("t6_d", reg_d, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_d", reg_d, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_en", reg_en, 0);
        req = '0;
        step(2);
        reset = 1'b0;
        base  = en_cnt;
        step(30);
        chk("t6_no_en", en_cnt - base, 0);
        chk("t6_pend_after", pending, 0);
        chk("t6_idle_after", busy, 0);
        chk("overlap_total", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
